// File: rtl/gpu_command_scheduler_if.sv
// Instruction-in / framebuffer-write-out bundle for the GPU command scheduler.
// Latency: none; this is only wiring.
// Backpressure: i_instruction_ready/o_instruction_ack handshake; o_fifo_full mirrors queue state.
interface gpu_command_scheduler_if #(
  parameter int ADDR_W = 15
);
  logic [31:0]       i_instruction;
  logic              i_instruction_ready;
  logic              o_instruction_ack;
  logic              o_fifo_full;
  logic              o_fb_we;
  logic [ADDR_W-1:0] o_fb_addr;
  logic [11:0]       o_fb_wdata;

  // Host side: offers instructions and watches framebuffer writes.
  modport master (
    output i_instruction, i_instruction_ready,
    input  o_instruction_ack, o_fifo_full, o_fb_we, o_fb_addr, o_fb_wdata
  );

  // Scheduler side.
  modport slave (
    input  i_instruction, i_instruction_ready,
    output o_instruction_ack, o_fifo_full, o_fb_we, o_fb_addr, o_fb_wdata
  );
endinterface

// File: rtl/gpu_command_scheduler.sv
// Queues 32-bit GPU instructions and turns them into framebuffer pixel writes (plot/fill/clear).
// Latency: word accepted in cycle N is decoded at N+1; first pixel write at N+2 with display idle.
// Backpressure: ack drops while the FIFO is full; writes stall in any cycle the display claims the port.
module gpu_command_scheduler #(
  parameter int FB_W       = 160,
  parameter int FB_H       = 120,
  parameter int ADDR_W     = 15,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                   i_clk,
  input  logic                   i_reset,
  gpu_command_scheduler_if.slave bus,
  input  logic                   i_disp_active,
  output logic                   o_busy,
  output logic                   o_error
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0]  DEPTH_C = CNT_W'(FIFO_DEPTH);
  localparam logic [10:0]       W_LIM   = 11'(FB_W);
  localparam logic [10:0]       H_LIM   = 11'(FB_H);
  localparam logic [ADDR_W-1:0] W_STEP  = ADDR_W'(FB_W);

  localparam logic [3:0] OP_NOP        = 4'h0;
  localparam logic [3:0] OP_SET_COLOR  = 4'h1;
  localparam logic [3:0] OP_PLOT       = 4'h2;
  localparam logic [3:0] OP_SET_ORIGIN = 4'h3;
  localparam logic [3:0] OP_FILL       = 4'h4;
  localparam logic [3:0] OP_CLEAR      = 4'h5;

  typedef enum logic [1:0] {S_IDLE, S_PLOT, S_FILL} state_t;

  typedef struct packed {
    logic [3:0] opcode;
    logic [7:0] rsvd;
    logic [9:0] a;   // x / width
    logic [9:0] b;   // y / height
  } instr_t;

  // y*FB_W as a constant shift-add so no multiplier is built.
  function automatic logic [ADDR_W-1:0] row_of(input logic [10:0] y);
    logic [ADDR_W-1:0] acc;
    acc = '0;
    for (int i = 0; i < ADDR_W; i++) begin
      if (W_STEP[i]) acc = acc + (ADDR_W'(y) << i);
    end
    return acc;
  endfunction

  // ---------------- instruction FIFO ----------------
  instr_t            fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr, rd_ptr;
  logic [CNT_W-1:0]  count;
  logic              fifo_full, fifo_empty, push, pop;
  instr_t            head;
  state_t            state, state_nxt;

  assign fifo_full  = (count == DEPTH_C);
  assign fifo_empty = (count == '0);
  assign push       = bus.i_instruction_ready && !fifo_full;
  assign pop        = (state == S_IDLE) && !fifo_empty;
  assign head       = fifo_mem[rd_ptr];

  assign bus.o_instruction_ack = push;
  assign bus.o_fifo_full       = fifo_full;

  // FIFO pointers and occupancy; simultaneous push and pop leave the count unchanged.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // FIFO storage; contents need no reset since the pointers gate every read.
  always_ff @(posedge i_clk) begin
    if (push) fifo_mem[wr_ptr] <= bus.i_instruction;
  end

  // ---------------- drawing state ----------------
  logic [11:0]       colour;
  logic [9:0]        ox, oy;
  logic [10:0]       cx, cy, x0, xl, yl;
  logic [ADDR_W-1:0] row_base, addr;
  logic [11:0]       wdata;
  logic              error_q;

  // Decode of the FIFO head: clipped rectangle bounds and first pixel address.
  logic [10:0]       dec_x0, dec_y0, dec_xl, dec_yl, x_end, y_end;
  logic              dec_empty;
  logic [ADDR_W-1:0] dec_row, dec_addr;
  logic              unused_rsvd;

  assign unused_rsvd = ^head.rsvd;

  // Bounds are 11 bits wide so origin+size can never overflow and wrap around.
  always_comb begin
    dec_x0 = '0;
    dec_y0 = '0;
    dec_xl = W_LIM;
    dec_yl = H_LIM;
    x_end  = {1'b0, ox} + {1'b0, head.a};
    y_end  = {1'b0, oy} + {1'b0, head.b};
    if (head.opcode == OP_PLOT) begin
      dec_x0 = {1'b0, head.a};
      dec_y0 = {1'b0, head.b};
    end else if (head.opcode == OP_FILL) begin
      dec_x0 = {1'b0, ox};
      dec_y0 = {1'b0, oy};
      dec_xl = (x_end > W_LIM) ? W_LIM : x_end;
      dec_yl = (y_end > H_LIM) ? H_LIM : y_end;
    end
    dec_empty = (dec_x0 >= dec_xl) || (dec_y0 >= dec_yl);
    dec_row   = row_of(dec_y0);
    dec_addr  = dec_row + ADDR_W'(dec_x0);
  end

  // FSM control signals.
  logic        ld_cmd, step_x, step_row, set_color, set_origin, set_err, fb_we_c;
  logic [10:0] cx_inc, cy_inc;

  assign cx_inc = cx + 11'd1;
  assign cy_inc = cy + 11'd1;

  // State register; reset abandons any plot or fill in progress.
  always_ff @(posedge i_clk) begin
    if (i_reset) state <= S_IDLE;
    else         state <= state_nxt;
  end

  // Next state and per-cycle actions: decode on pop, one pixel per display-free cycle.
  always_comb begin
    state_nxt  = state;
    ld_cmd     = 1'b0;
    step_x     = 1'b0;
    step_row   = 1'b0;
    set_color  = 1'b0;
    set_origin = 1'b0;
    set_err    = 1'b0;
    fb_we_c    = 1'b0;
    case (state)
      S_IDLE: begin
        if (pop) begin
          case (head.opcode)
            OP_NOP:        ;
            OP_SET_COLOR:  set_color  = 1'b1;
            OP_SET_ORIGIN: set_origin = 1'b1;
            OP_PLOT: begin
              if (!dec_empty) begin
                ld_cmd    = 1'b1;
                state_nxt = S_PLOT;
              end
            end
            OP_FILL, OP_CLEAR: begin
              if (!dec_empty) begin
                ld_cmd    = 1'b1;
                state_nxt = S_FILL;
              end
            end
            default:       set_err = 1'b1;
          endcase
        end
      end
      S_PLOT: begin
        if (!i_disp_active) begin
          fb_we_c   = 1'b1;
          state_nxt = S_IDLE;
        end
      end
      S_FILL: begin
        if (!i_disp_active) begin
          fb_we_c = 1'b1;
          if (cx_inc < xl)      step_x    = 1'b1;
          else if (cy_inc < yl) step_row  = 1'b1;
          else                  state_nxt = S_IDLE;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Colour/origin registers, cursor, row base and the registered address/data.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      colour   <= '0;
      ox       <= '0;
      oy       <= '0;
      cx       <= '0;
      cy       <= '0;
      x0       <= '0;
      xl       <= '0;
      yl       <= '0;
      row_base <= '0;
      addr     <= '0;
      wdata    <= '0;
      error_q  <= 1'b0;
    end else begin
      if (set_color) colour <= head[11:0];
      if (set_origin) begin
        ox <= head.a;
        oy <= head.b;
      end
      if (set_err) error_q <= 1'b1;
      if (ld_cmd) begin
        cx       <= dec_x0;
        cy       <= dec_y0;
        x0       <= dec_x0;
        xl       <= dec_xl;
        yl       <= dec_yl;
        row_base <= dec_row;
        addr     <= dec_addr;
        wdata    <= colour;
      end
      if (step_x) begin
        cx   <= cx_inc;
        addr <= addr + ADDR_W'(1);
      end
      if (step_row) begin
        cx       <= x0;
        cy       <= cy_inc;
        row_base <= row_base + W_STEP;
        addr     <= row_base + W_STEP + ADDR_W'(x0);
      end
    end
  end

  // Strobe comes from the state register, qualified by the live display claim so it never collides with scan-out.
  assign bus.o_fb_we    = fb_we_c;
  assign bus.o_fb_addr  = addr;
  assign bus.o_fb_wdata = wdata;
  assign o_busy         = !fifo_empty || (state != S_IDLE);
  assign o_error        = error_q;

endmodule

// File: tb/tb_gpu_command_scheduler.sv
// Scoreboard bench for gpu_command_scheduler: expected pixel writes are queued as commands are sent.
// A negedge monitor records every framebuffer write; each test task pops and compares.
// Display contention is driven directly from the test tasks.
module tb_gpu_command_scheduler;
  localparam int FB_W = 160;
  localparam int FB_H = 120;
  localparam int ADDR_W = 15;
  localparam logic [3:0] OP_NOP = 4'h0, OP_SET_COLOR = 4'h1, OP_PLOT = 4'h2,
                         OP_SET_ORIGIN = 4'h3, OP_FILL = 4'h4, OP_CLEAR = 4'h5;

  typedef struct { int addr; int data; int cyc; } wr_t;

  logic i_clk = 1'b0;
  logic i_reset = 1'b1;
  logic i_disp_active = 1'b0;
  logic o_busy, o_error;
  int   cyc = 0;
  int   tests = 0;
  int   failed = 0;
  int   viol = 0;
  wr_t  obs[$];
  wr_t  exp_q[$];

  gpu_command_scheduler_if #(.ADDR_W(ADDR_W)) bus ();

  gpu_command_scheduler #(.FB_W(FB_W), .FB_H(FB_H), .ADDR_W(ADDR_W), .FIFO_DEPTH(4)) dut (
    .i_clk(i_clk), .i_reset(i_reset), .bus(bus.slave),
    .i_disp_active(i_disp_active), .o_busy(o_busy), .o_error(o_error)
  );

  always #5 i_clk = ~i_clk;
  always @(posedge i_clk) cyc <= cyc + 1;

  function automatic wr_t wr(input int a, input int d, input int c);
    wr_t r;
    r.addr = a; r.data = d; r.cyc = c;
    return r;
  endfunction

  function automatic logic [31:0] mk(input logic [3:0] op, input int a, input int b);
    return {op, 8'h00, 10'(a), 10'(b)};
  endfunction

  always @(negedge i_clk) begin
    if (bus.o_fb_we === 1'b1) begin
      obs.push_back(wr(int'(bus.o_fb_addr), int'(bus.o_fb_wdata), cyc));
      if (i_disp_active) viol++;
    end
  end

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic send(input logic [31:0] w, output int acc);
    acc = -1;
    bus.i_instruction = w;
    bus.i_instruction_ready = 1'b1;
    for (int t = 0; t < 400 && acc < 0; t++) begin
      @(negedge i_clk);
      if (bus.o_instruction_ack === 1'b1) acc = cyc;
      @(posedge i_clk);
      #1;
    end
    bus.i_instruction_ready = 1'b0;
    if (acc < 0) begin
      tests++; failed++;
      $display("FAIL send_timeout word=%08h got no ack want ack", w);
    end
  endtask

  task automatic wait_idle(input string nm);
    int t = 0;
    while (o_busy !== 1'b0 && t < 30000) begin tick(); t++; end
    if (o_busy !== 1'b0) begin
      tests++; failed++;
      $display("FAIL %s_idle_timeout got busy=%b want 0", nm, o_busy);
    end
    repeat (2) tick();
  endtask

  task automatic test_reset();
    logic [31:0] got[7];
    string nm[7];
    i_reset = 1'b1;
    repeat (3) tick();
    i_reset = 1'b0;
    @(negedge i_clk);
    got[0] = 32'(bus.o_fb_we);     nm[0] = "we";
    got[1] = 32'(bus.o_fb_addr);   nm[1] = "addr";
    got[2] = 32'(bus.o_fb_wdata);  nm[2] = "wdata";
    got[3] = 32'(o_busy);          nm[3] = "busy";
    got[4] = 32'(o_error);         nm[4] = "error";
    got[5] = 32'(bus.o_fifo_full); nm[5] = "full";
    got[6] = 32'(bus.o_instruction_ack); nm[6] = "ack";
    for (int i = 0; i < 7; i++) begin
      tests++;
      if (got[i] !== 32'd0) begin
        failed++;
        $display("FAIL reset_%s got %0h want 0", nm[i], got[i]);
      end
    end
    tick();
    obs.delete();
  endtask

  task automatic test_plot();
    int acc;
    wr_t e, o;
    send(mk(OP_SET_COLOR, 0, 12'h0F0), acc);
    send(mk(OP_PLOT, 3, 2), acc);
    exp_q.push_back(wr(2 * FB_W + 3, 12'h0F0, acc + 2));
    wait_idle("plot");
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); tests++;
      if (obs.size() == 0) begin
        failed++; $display("FAIL plot_write got none want addr=%0d data=%03h", e.addr, e.data);
      end else begin
        o = obs.pop_front();
        if (o.addr !== e.addr || o.data !== e.data || o.cyc !== e.cyc) begin
          failed++;
          $display("FAIL plot_write got addr=%0d data=%03h cyc=%0d want addr=%0d data=%03h cyc=%0d",
                   o.addr, o.data, o.cyc, e.addr, e.data, e.cyc);
        end
      end
    end
    tests++;
    if (obs.size() != 0) begin failed++; $display("FAIL plot_extra got %0d extra writes want 0", obs.size()); end
  endtask

  task automatic test_fill_stall();
    int acc, t;
    wr_t e, o;
    viol = 0;
    i_disp_active = 1'b1;
    send(mk(OP_SET_ORIGIN, 10, 5), acc);
    send(mk(OP_FILL, 3, 2), acc);
    for (int y = 5; y < 7; y++)
      for (int x = 10; x < 13; x++) exp_q.push_back(wr(y * FB_W + x, 12'h0F0, -1));
    t = 0;
    while (o_busy !== 1'b0 && t < 200) begin tick(); i_disp_active = ~i_disp_active; t++; end
    i_disp_active = 1'b0;
    wait_idle("fill");
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); tests++;
      if (obs.size() == 0) begin
        failed++; $display("FAIL fill_write got none want addr=%0d", e.addr);
      end else begin
        o = obs.pop_front();
        if (o.addr !== e.addr || o.data !== e.data) begin
          failed++;
          $display("FAIL fill_write got addr=%0d data=%03h want addr=%0d data=%03h", o.addr, o.data, e.addr, e.data);
        end
      end
    end
    tests++;
    if (obs.size() != 0) begin failed++; $display("FAIL fill_extra got %0d extra writes want 0", obs.size()); end
    tests++;
    if (viol != 0) begin failed++; $display("FAIL fill_disp_collision got %0d writes during display want 0", viol); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] w[6];
    int n = 0, blk = 0, n_at_block = -1;
    bit full_seen = 1'b0;
    wr_t e, o;
    for (int i = 0; i < 6; i++) begin
      w[i] = mk(OP_PLOT, i, 7);
      exp_q.push_back(wr(7 * FB_W + i, 12'h0F0, -1));
    end
    i_disp_active = 1'b1;
    bus.i_instruction = w[0];
    bus.i_instruction_ready = 1'b1;
    for (int t = 0; t < 60 && n < 6; t++) begin
      @(negedge i_clk);
      if (bus.o_instruction_ack === 1'b1) n++;
      else begin
        blk++;
        if (bus.o_fifo_full === 1'b1) full_seen = 1'b1;
        if (blk == 3) n_at_block = n;
      end
      @(posedge i_clk);
      #1;
      if (n < 6) bus.i_instruction = w[n];
      if (blk >= 3) i_disp_active = 1'b0;
    end
    bus.i_instruction_ready = 1'b0;
    i_disp_active = 1'b0;
    wait_idle("b2b");
    tests++;
    if (n_at_block !== 5) begin failed++; $display("FAIL b2b_accepted_before_block got %0d want 5", n_at_block); end
    tests++;
    if (full_seen !== 1'b1) begin failed++; $display("FAIL b2b_full got %b want 1", full_seen); end
    tests++;
    if (n !== 6) begin failed++; $display("FAIL b2b_total_accepted got %0d want 6", n); end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); tests++;
      if (obs.size() == 0) begin
        failed++; $display("FAIL b2b_write got none want addr=%0d", e.addr);
      end else begin
        o = obs.pop_front();
        if (o.addr !== e.addr || o.data !== e.data) begin
          failed++;
          $display("FAIL b2b_write got addr=%0d data=%03h want addr=%0d data=%03h", o.addr, o.data, e.addr, e.data);
        end
      end
    end
    tests++;
    if (obs.size() != 0) begin failed++; $display("FAIL b2b_extra got %0d extra writes want 0", obs.size()); end
  endtask

  task automatic test_clip();
    int acc;
    wr_t e, o;
    send(mk(OP_SET_ORIGIN, 158, 119), acc);
    send(mk(OP_FILL, 5, 3), acc);
    exp_q.push_back(wr(19198, 12'h0F0, -1));
    exp_q.push_back(wr(19199, 12'h0F0, -1));
    wait_idle("clip");
    tests++;
    if (o_busy !== 1'b0) begin failed++; $display("FAIL clip_busy got %b want 0", o_busy); end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); tests++;
      if (obs.size() == 0) begin
        failed++; $display("FAIL clip_write got none want addr=%0d", e.addr);
      end else begin
        o = obs.pop_front();
        if (o.addr !== e.addr || o.data !== e.data) begin
          failed++;
          $display("FAIL clip_write got addr=%0d data=%03h want addr=%0d data=%03h", o.addr, o.data, e.addr, e.data);
        end
      end
    end
    tests++;
    if (obs.size() != 0) begin failed++; $display("FAIL clip_extra got %0d extra writes want 0", obs.size()); end
    send(mk(OP_SET_ORIGIN, 10, 5), acc);
    send(mk(OP_FILL, 0, 2), acc);
    send(mk(OP_FILL, 4, 0), acc);
    send(mk(OP_PLOT, 160, 0), acc);
    send(mk(OP_PLOT, 0, 120), acc);
    wait_idle("empty");
    tests++;
    if (obs.size() != 0) begin failed++; $display("FAIL empty_cmds got %0d writes want 0", obs.size()); end
    obs.delete();
  endtask

  task automatic test_error();
    int acc;
    wr_t e, o;
    tests++;
    if (o_error !== 1'b0) begin failed++; $display("FAIL error_initial got %b want 0", o_error); end
    send(mk(OP_PLOT, 1, 1), acc);
    send(32'h9000_0000, acc);
    send(mk(OP_PLOT, 2, 1), acc);
    exp_q.push_back(wr(FB_W + 1, 12'h0F0, -1));
    exp_q.push_back(wr(FB_W + 2, 12'h0F0, -1));
    wait_idle("error");
    tests++;
    if (o_error !== 1'b1) begin failed++; $display("FAIL error_set got %b want 1", o_error); end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); tests++;
      if (obs.size() == 0) begin
        failed++; $display("FAIL error_plot got none want addr=%0d", e.addr);
      end else begin
        o = obs.pop_front();
        if (o.addr !== e.addr || o.data !== e.data) begin
          failed++;
          $display("FAIL error_plot got addr=%0d data=%03h want addr=%0d data=%03h", o.addr, o.data, e.addr, e.data);
        end
      end
    end
    send(mk(OP_NOP, 0, 0), acc);
    wait_idle("error_nop");
    tests++;
    if (o_error !== 1'b1) begin failed++; $display("FAIL error_sticky got %b want 1", o_error); end
    tests++;
    if (obs.size() != 0) begin failed++; $display("FAIL error_extra got %0d extra writes want 0", obs.size()); end
  endtask

  task automatic test_reset_mid_clear();
    int acc;
    wr_t e, o;
    send(mk(OP_SET_COLOR, 0, 12'h123), acc);
    send(mk(OP_CLEAR, 0, 0), acc);
    repeat (10) tick();
    tests++;
    if (obs.size() == 0 || o_busy !== 1'b1) begin
      failed++; $display("FAIL clear_started got writes=%0d busy=%b want >0 and 1", obs.size(), o_busy);
    end
    i_reset = 1'b1;
    tick();
    @(negedge i_clk);
    tests++;
    if (bus.o_fb_we !== 1'b0 || o_busy !== 1'b0 || bus.o_fb_wdata !== 12'h000 || o_error !== 1'b0) begin
      failed++;
      $display("FAIL reset_mid_clear got we=%b busy=%b wdata=%03h err=%b want 0 0 000 0",
               bus.o_fb_we, o_busy, bus.o_fb_wdata, o_error);
    end
    @(posedge i_clk);
    #1;
    i_reset = 1'b0;
    obs.delete();
    send(mk(OP_PLOT, 5, 5), acc);
    exp_q.push_back(wr(5 * FB_W + 5, 12'h000, -1));
    wait_idle("post_reset");
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); tests++;
      if (obs.size() == 0) begin
        failed++; $display("FAIL post_reset_plot got none want addr=%0d", e.addr);
      end else begin
        o = obs.pop_front();
        if (o.addr !== e.addr || o.data !== e.data) begin
          failed++;
          $display("FAIL post_reset_plot got addr=%0d data=%03h want addr=%0d data=%03h", o.addr, o.data, e.addr, e.data);
        end
      end
    end
    tests++;
    if (obs.size() != 0) begin failed++; $display("FAIL post_reset_extra got %0d extra writes want 0", obs.size()); end
  endtask

  initial begin
    bus.i_instruction = '0;
    bus.i_instruction_ready = 1'b0;
    test_reset();
    test_plot();
    test_fill_stall();
    test_back_to_back();
    test_clip();
    test_error();
    test_reset_mid_clear();
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog got no completion want finish");
    $fatal(1);
  end
endmodule
